// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word and register-index widths plus the EX/MEM
// memory-handshake state encoding.
package cpu_types_pkg;
  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } exmem_state_t;
endpackage

// File: rtl/iexec_mem_if.sv
// Port bundle between the EX/MEM latch (em_if) and its environment (tb).
interface iexec_mem_if;
  import cpu_types_pkg::*;

  logic     ihit, dhit, stall, flush;
  word_t    instr_in, pcplusfour_in, alu_out_in, rdat2_in;
  regbits_t wsel_in;
  logic     RegWr_in, MemtoReg_in, dREN_in, dWEN_in, jal_s_in, halt_in;
  word_t    dmemload;

  word_t    instr_out, pcplusfour_out, alu_out_out, rdat2_out;
  regbits_t wsel_out;
  logic     RegWr_out, MemtoReg_out, jal_s_out, halt_out;
  logic     dREN_out, dWEN_out;
  word_t    dmemaddr, dmemstore, dmemload_out;
  logic     mem_busy;
  logic [31:0] stall_cycles;

  modport em_if (
    input  ihit, dhit, stall, flush,
    input  instr_in, pcplusfour_in, alu_out_in, rdat2_in, wsel_in,
    input  RegWr_in, MemtoReg_in, dREN_in, dWEN_in, jal_s_in, halt_in,
    input  dmemload,
    output instr_out, pcplusfour_out, alu_out_out, rdat2_out, wsel_out,
    output RegWr_out, MemtoReg_out, jal_s_out, halt_out,
    output dREN_out, dWEN_out, dmemaddr, dmemstore, dmemload_out,
    output mem_busy, stall_cycles
  );

  modport tb (
    output ihit, dhit, stall, flush,
    output instr_in, pcplusfour_in, alu_out_in, rdat2_in, wsel_in,
    output RegWr_in, MemtoReg_in, dREN_in, dWEN_in, jal_s_in, halt_in,
    output dmemload,
    input  instr_out, pcplusfour_out, alu_out_out, rdat2_out, wsel_out,
    input  RegWr_out, MemtoReg_out, jal_s_out, halt_out,
    input  dREN_out, dWEN_out, dmemaddr, dmemstore, dmemload_out,
    input  mem_busy, stall_cycles
  );
endinterface

// File: rtl/iexec_mem.sv
// EX/MEM pipeline latch owning the data-cache handshake.
// Optional ACCESS-cycle counter on stall_cycles when IEXMEM_STALLCNT_EN is defined.
module iexec_mem
  import cpu_types_pkg::*;
(
  input logic        CLK,
  input logic        RST,
  iexec_mem_if.em_if emif
);

  exmem_state_t state, next_state;
  logic         adv;
  logic         mem_req;

  word_t    instr_p0, pc4_p0, alu_p0, rdat2_p0, load_p0;
  regbits_t wsel_p0;
  logic     regwr_p0, memtoreg_p0, jal_p0, halt_p0, dren_p0, dwen_p0;

  assign adv     = emif.ihit & ~emif.stall & (state != ACCESS);
  assign mem_req = ~emif.flush & (emif.dREN_in | emif.dWEN_in);

  always_comb begin
    next_state = state;
    case (state)
      ACCESS:  if (emif.dhit) next_state = DONE;
      default: if (adv) next_state = mem_req ? ACCESS : IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      instr_p0    <= '0;
      pc4_p0      <= '0;
      alu_p0      <= '0;
      rdat2_p0    <= '0;
      wsel_p0     <= '0;
      regwr_p0    <= 1'b0;
      memtoreg_p0 <= 1'b0;
      jal_p0      <= 1'b0;
      halt_p0     <= 1'b0;
      dren_p0     <= 1'b0;
      dwen_p0     <= 1'b0;
      load_p0     <= '0;
    end else begin
      state <= next_state;
      if (adv) begin
        if (emif.flush) begin
          instr_p0    <= '0;
          pc4_p0      <= '0;
          alu_p0      <= '0;
          rdat2_p0    <= '0;
          wsel_p0     <= '0;
          regwr_p0    <= 1'b0;
          memtoreg_p0 <= 1'b0;
          jal_p0      <= 1'b0;
          halt_p0     <= 1'b0;
          dren_p0     <= 1'b0;
          dwen_p0     <= 1'b0;
        end else begin
          instr_p0    <= emif.instr_in;
          pc4_p0      <= emif.pcplusfour_in;
          alu_p0      <= emif.alu_out_in;
          rdat2_p0    <= emif.rdat2_in;
          wsel_p0     <= emif.wsel_in;
          regwr_p0    <= emif.RegWr_in;
          memtoreg_p0 <= emif.MemtoReg_in;
          jal_p0      <= emif.jal_s_in;
          halt_p0     <= emif.halt_in;
          // a write wins when both request bits are set
          dren_p0     <= emif.dREN_in & ~emif.dWEN_in;
          dwen_p0     <= emif.dWEN_in;
        end
      end
      if (state == ACCESS && emif.dhit && dren_p0)
        load_p0 <= emif.dmemload;
    end
  end

  assign emif.instr_out      = instr_p0;
  assign emif.pcplusfour_out = pc4_p0;
  assign emif.alu_out_out    = alu_p0;
  assign emif.rdat2_out      = rdat2_p0;
  assign emif.wsel_out       = wsel_p0;
  assign emif.RegWr_out      = regwr_p0;
  assign emif.MemtoReg_out   = memtoreg_p0;
  assign emif.jal_s_out      = jal_p0;
  assign emif.halt_out       = halt_p0;
  assign emif.dREN_out       = (state == ACCESS) & dren_p0;
  assign emif.dWEN_out       = (state == ACCESS) & dwen_p0;
  assign emif.dmemaddr       = alu_p0;
  assign emif.dmemstore      = rdat2_p0;
  assign emif.dmemload_out   = load_p0;
  assign emif.mem_busy       = (state == ACCESS);

`ifdef IEXMEM_STALLCNT_EN
  logic [31:0] stall_cnt_p0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST)                  stall_cnt_p0 <= '0;
    else if (state == ACCESS) stall_cnt_p0 <= sat_inc(stall_cnt_p0);
  end

  assign emif.stall_cycles = stall_cnt_p0;
`else
  assign emif.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_iexec_mem.sv
// Randomized self-checking bench for iexec_mem against a transaction-level model.
module tb_iexec_mem;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  iexec_mem_if emif();
  iexec_mem dut (.CLK(CLK), .RST(RST), .emif(emif));

  always #5 CLK = ~CLK;

  // Model: latched instruction record plus an "outstanding memory op" flag.
  word_t    m_instr, m_pc4, m_alu, m_rdat2, m_load;
  regbits_t m_wsel;
  logic     m_regwr, m_mtr, m_jal, m_halt, m_rd, m_wr, m_pending;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    m_instr = 0; m_pc4 = 0; m_alu = 0; m_rdat2 = 0; m_wsel = 0;
    m_regwr = 0; m_mtr = 0; m_jal = 0; m_halt = 0; m_rd = 0; m_wr = 0;
  endtask

  task automatic model_step();
    logic was_pending, go;
    if (RST) begin
      clear_model();
      m_pending = 0; m_load = 0; m_cnt = 0;
    end else begin
      was_pending = m_pending;
      go = emif.ihit && !emif.stall && !was_pending;
      if (was_pending) begin
`ifdef IEXMEM_STALLCNT_EN
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
        if (emif.dhit) begin
          if (m_rd) m_load = emif.dmemload;
          m_pending = 0;
        end
      end
      if (go) begin
        if (emif.flush) begin
          clear_model();
          m_pending = 0;
        end else begin
          m_instr = emif.instr_in; m_pc4 = emif.pcplusfour_in;
          m_alu = emif.alu_out_in; m_rdat2 = emif.rdat2_in; m_wsel = emif.wsel_in;
          m_regwr = emif.RegWr_in; m_mtr = emif.MemtoReg_in;
          m_jal = emif.jal_s_in; m_halt = emif.halt_in;
          m_wr = emif.dWEN_in;
          m_rd = emif.dREN_in && !emif.dWEN_in;
          m_pending = emif.dREN_in || emif.dWEN_in;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("instr_out", emif.instr_out, m_instr);
    chk("pcplusfour_out", emif.pcplusfour_out, m_pc4);
    chk("alu_out_out", emif.alu_out_out, m_alu);
    chk("rdat2_out", emif.rdat2_out, m_rdat2);
    chk("wsel_out", 32'(emif.wsel_out), 32'(m_wsel));
    chk("RegWr_out", 32'(emif.RegWr_out), 32'(m_regwr));
    chk("MemtoReg_out", 32'(emif.MemtoReg_out), 32'(m_mtr));
    chk("jal_s_out", 32'(emif.jal_s_out), 32'(m_jal));
    chk("halt_out", 32'(emif.halt_out), 32'(m_halt));
    chk("dREN_out", 32'(emif.dREN_out), 32'(m_pending && m_rd));
    chk("dWEN_out", 32'(emif.dWEN_out), 32'(m_pending && m_wr));
    chk("dmemaddr", emif.dmemaddr, m_alu);
    chk("dmemstore", emif.dmemstore, m_rdat2);
    chk("dmemload_out", emif.dmemload_out, m_load);
    chk("mem_busy", 32'(emif.mem_busy), 32'(m_pending));
    chk("stall_cycles", emif.stall_cycles, m_cnt);
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic drive_idle();
    RST = 0;
    emif.ihit = 0; emif.dhit = 0; emif.stall = 0; emif.flush = 0;
    emif.instr_in = 0; emif.pcplusfour_in = 0; emif.alu_out_in = 0; emif.rdat2_in = 0;
    emif.wsel_in = 0; emif.RegWr_in = 0; emif.MemtoReg_in = 0; emif.dREN_in = 0;
    emif.dWEN_in = 0; emif.jal_s_in = 0; emif.halt_in = 0; emif.dmemload = 0;
  endtask

  task automatic drive_lw(input word_t addr);
    drive_idle();
    emif.ihit = 1; emif.instr_in = 32'h8C45_0080; emif.pcplusfour_in = 32'h0000_0104;
    emif.alu_out_in = addr; emif.wsel_in = 5'd5; emif.RegWr_in = 1;
    emif.MemtoReg_in = 1; emif.dREN_in = 1;
  endtask

  task automatic drive_random();
    RST = ($urandom_range(0, 99) < 2);
    emif.ihit = ($urandom_range(0, 3) != 0);
    emif.dhit = ($urandom_range(0, 4) < 2);
    emif.stall = ($urandom_range(0, 4) == 0);
    emif.flush = ($urandom_range(0, 6) == 0);
    emif.instr_in = $urandom; emif.pcplusfour_in = $urandom;
    emif.alu_out_in = $urandom; emif.rdat2_in = $urandom;
    emif.wsel_in = 5'($urandom); emif.RegWr_in = 1'($urandom);
    emif.MemtoReg_in = 1'($urandom); emif.jal_s_in = 1'($urandom);
    emif.halt_in = 1'($urandom); emif.dmemload = $urandom;
    emif.dREN_in = ($urandom_range(0, 2) == 0);
    emif.dWEN_in = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    m_pending = 0; m_load = 0; m_cnt = 0;
    clear_model();
    drive_idle();
    RST = 1;
    cycle();
    chk("reset_state", emif.instr_out | emif.alu_out_out | 32'(emif.mem_busy), 32'h0);

    // reset in the middle of a load
    drive_lw(32'h0000_0080);
    cycle();
    chk("lw_pre_reset_dREN", 32'(emif.dREN_out), 32'd1);
    drive_idle(); RST = 1; emif.ihit = 1; emif.dhit = 1; emif.flush = 1;
    cycle();
    chk("rst_mid_dREN", 32'(emif.dREN_out), 32'd0);
    chk("rst_mid_busy", 32'(emif.mem_busy), 32'd0);
    chk("rst_mid_alu", emif.alu_out_out, 32'd0);

    // plain ALU op
    drive_idle();
    emif.ihit = 1; emif.instr_in = 32'h0022_2821; emif.wsel_in = 5'd5;
    emif.RegWr_in = 1; emif.alu_out_in = 32'h0000_0010;
    cycle();
    chk("addu_alu", emif.alu_out_out, 32'h10);
    chk("addu_wsel", 32'(emif.wsel_out), 32'd5);
    chk("addu_regwr", 32'(emif.RegWr_out), 32'd1);
    chk("addu_busy", 32'(emif.mem_busy), 32'd0);

    // load handshake with three miss cycles
    drive_lw(32'h0000_0080);
    cycle();
    chk("lw_dREN", 32'(emif.dREN_out), 32'd1);
    chk("lw_addr", emif.dmemaddr, 32'h80);
    emif.alu_out_in = 32'h0000_0F00; emif.dREN_in = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("lw_wait_busy", 32'(emif.mem_busy), 32'd1);
      chk("lw_wait_addr", emif.dmemaddr, 32'h80);
    end
    emif.dhit = 1; emif.dmemload = 32'hDEAD_BEEF;
    cycle();
    chk("lw_hit_dREN", 32'(emif.dREN_out), 32'd0);
    chk("lw_hit_load", emif.dmemload_out, 32'hDEAD_BEEF);
    chk("lw_hit_noadv", emif.alu_out_out, 32'h80);
    emif.dhit = 0;
    cycle();
    chk("lw_done_adv", emif.alu_out_out, 32'h0F00);

    // store, then a flush loads a bubble
    drive_idle();
    emif.ihit = 1; emif.instr_in = 32'hAC45_0000; emif.dWEN_in = 1;
    emif.rdat2_in = 32'h0000_1234; emif.alu_out_in = 32'h40;
    cycle();
    chk("sw_dWEN", 32'(emif.dWEN_out), 32'd1);
    chk("sw_store", emif.dmemstore, 32'h1234);
    chk("sw_keep_load", emif.dmemload_out, 32'hDEAD_BEEF);
    emif.dhit = 1; emif.dmemload = 32'h5555_5555;
    cycle();
    chk("sw_no_capture", emif.dmemload_out, 32'hDEAD_BEEF);
    emif.dhit = 0; emif.flush = 1; emif.RegWr_in = 1;
    cycle();
    chk("flush_regwr", 32'(emif.RegWr_out), 32'd0);
    chk("flush_dWEN", 32'(emif.dWEN_out), 32'd0);
    chk("flush_instr", emif.instr_out, 32'd0);

    // stall hold, flush during stall dropped
    drive_idle();
    emif.ihit = 1; emif.instr_in = 32'h1111_1111; emif.alu_out_in = 32'h22; emif.RegWr_in = 1;
    cycle();
    emif.stall = 1; emif.instr_in = 32'h3333_3333; emif.alu_out_in = 32'h44;
    cycle();
    emif.flush = 1; emif.instr_in = 32'h5555_5555;
    cycle();
    chk("stall_instr", emif.instr_out, 32'h1111_1111);
    chk("stall_regwr", 32'(emif.RegWr_out), 32'd1);

    // four ACCESS cycles for the counter
    drive_idle(); RST = 1;
    cycle();
    drive_lw(32'h0000_0100);
    cycle();
    emif.dREN_in = 0;
    for (int i = 0; i < 3; i++) cycle();
    emif.dhit = 1;
    cycle();
`ifdef IEXMEM_STALLCNT_EN
    chk("stall_cnt4", emif.stall_cycles, 32'd4);
`else
    chk("stall_cnt_off", emif.stall_cycles, 32'd0);
`endif

    for (int i = 0; i < 600; i++) begin
      drive_random();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
